// File: rtl/rv32i_types.sv
// RV32I shared types: opcodes, immediate formats, NOP.
// Includes the immediate-format selector and the 32-bit immediate builder.
package rv32i_types;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_e;

  typedef enum logic [2:0] {
    IMM_R,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  localparam logic [31:0] NOP = 32'h00000013;

  function automatic imm_type_e imm_type(input logic [6:0] op);
    imm_type_e t;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR: t = IMM_I;
      OP_STORE:                 t = IMM_S;
      OP_BRANCH:                t = IMM_B;
      OP_LUI, OP_AUIPC:         t = IMM_U;
      OP_JAL:                   t = IMM_J;
      default:                  t = IMM_R;
    endcase
    return t;
  endfunction

  function automatic logic [31:0] imm32(
    input logic [31:0] i,
    input imm_type_e   t
  );
    logic [31:0] r;
    case (t)
      IMM_I: r = {{20{i[31]}}, i[31:20]};
      IMM_S: r = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B: r = {{19{i[31]}}, i[31], i[7],
                  i[30:25], i[11:8], 1'b0};
      IMM_U: r = {i[31:12], 12'b0};
      IMM_J: r = {{11{i[31]}}, i[31], i[19:12],
                  i[20], i[30:21], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_pipe_stage_regfile.sv
// Register file: two combinational reads, one write.
// x0 is hardwired to zero; optional same-cycle write forwarding.
module regfile_param #(
  parameter int NREGS     = 32,
  parameter int XLEN      = 32,
  parameter bit WB_BYPASS = 1'b1,
  localparam int RW       = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RW-1:0]   rs1_idx,
  input  logic [RW-1:0]   rs2_idx,
  output logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] rs2_val,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_idx,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] mem [NREGS];
  logic            wr_live;

  assign wr_live = wr_en && (wr_idx != '0);

  // Storage update; writes to x0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_live) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Read port 1 with optional writeback forwarding.
  always_comb begin
    rs1_val = mem[rs1_idx];
    if (rs1_idx == '0)
      rs1_val = '0;
    else if (WB_BYPASS && wr_live && wr_idx == rs1_idx)
      rs1_val = wr_data;
  end

  // Read port 2 with optional writeback forwarding.
  always_comb begin
    rs2_val = mem[rs2_idx];
    if (rs2_idx == '0)
      rs2_val = '0;
    else if (WB_BYPASS && wr_live && wr_idx == rs2_idx)
      rs2_val = wr_data;
  end

endmodule

// File: rtl/decode_pipe_stage.sv
// RV32I decode stage: operand read, immediate gen, busy-bit hazard
// check and a single output register with valid/ready handshake.
module decode_pipe_stage
  import rv32i_types::*;
#(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter bit WB_BYPASS = 1'b1,
  localparam int RW       = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic            wb_valid,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm,
  output logic [RW-1:0]   out_rd,
  output logic            out_rd_we
);

  logic [6:0]      opc;
  logic [RW-1:0]   rs1, rs2, rd;
  logic [XLEN-1:0] rs1_val, rs2_val, imm_ext;
  logic [31:0]     imm_raw;
  logic            use_rs1, use_rs2, wr_rd, rd_we;
  logic            hz1, hz2, hazard, load;
  logic            set_busy;
  logic [NREGS-1:0] busy, busy_nxt;

  assign opc = in_instr[6:0];
  assign rs1 = in_instr[15 +: RW];
  assign rs2 = in_instr[20 +: RW];
  assign rd  = in_instr[7 +: RW];

  assign imm_raw = imm32(in_instr, imm_type(opc));
  assign imm_ext = XLEN'($signed(imm_raw));

  regfile_param #(
    .NREGS     (NREGS),
    .XLEN      (XLEN),
    .WB_BYPASS (WB_BYPASS)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .rs1_idx (rs1),
    .rs2_idx (rs2),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .wr_en   (wb_valid),
    .wr_idx  (wb_rd),
    .wr_data (wb_data)
  );

  // Which sources are read and whether rd is written.
  always_comb begin
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    wr_rd   = 1'b1;
    unique case (1'b1)
      (opc == OP_LUI) || (opc == OP_AUIPC) ||
      (opc == OP_JAL): use_rs1 = 1'b0;
      (opc == OP_BRANCH) || (opc == OP_STORE): begin
        use_rs2 = 1'b1;
        wr_rd   = 1'b0;
      end
      (opc == OP_REG): use_rs2 = 1'b1;
      default: ;
    endcase
  end

  assign rd_we = wr_rd && (rd != '0);

  // A source stalls on a pending busy bit not satisfied by this
  // cycle's writeback, or on the producer sitting in the output reg.
  always_comb begin
    hz1 = use_rs1 && (rs1 != '0) &&
          ((busy[rs1] &&
            !(WB_BYPASS && wb_valid && wb_rd == rs1)) ||
           (out_valid && out_rd_we && out_rd == rs1));
    hz2 = use_rs2 && (rs2 != '0) &&
          ((busy[rs2] &&
            !(WB_BYPASS && wb_valid && wb_rd == rs2)) ||
           (out_valid && out_rd_we && out_rd == rs2));
  end

  assign hazard   = hz1 || hz2;
  assign in_ready = !rst && !hazard && !flush &&
                    (!out_valid || out_ready);
  assign load     = in_valid && in_ready;
  assign set_busy = out_valid && out_ready && out_rd_we && !flush;

  // Next busy vector: clear on writeback, set on issue (set wins).
  always_comb begin
    busy_nxt = busy;
    if (wb_valid) busy_nxt[wb_rd] = 1'b0;
    if (set_busy) busy_nxt[out_rd] = 1'b1;
  end

  // Scoreboard state.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  // Output register: reset, flush kill, load, or drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_instr   <= NOP;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_imm     <= '0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_instr <= NOP;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_instr   <= in_instr;
      out_rs1_val <= rs1_val;
      out_rs2_val <= rs2_val;
      out_imm     <= imm_ext;
      out_rd      <= rd;
      out_rd_we   <= rd_we;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Bench for decode_pipe_stage: directed vectors, expected results
// queued at issue and compared by a monitor on each output handshake.
module tb_decode_pipe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_instr;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr, out_rs1_val, out_rs2_val, out_imm;
  logic [4:0]  out_rd;
  logic        out_rd_we;

  logic        v64, rdy64;
  logic [63:0] pc64;
  logic [31:0] instr64;
  logic        ov64, orwe64;
  logic [63:0] opc64, ors1_64, ors2_64, oimm64;
  logic [31:0] oinstr64;
  logic [3:0]  ord64;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  decode_pipe_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_imm(out_imm), .out_rd(out_rd), .out_rd_we(out_rd_we)
  );

  decode_pipe_stage #(.XLEN(64), .NREGS(16)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(v64), .in_ready(rdy64),
    .in_pc(pc64), .in_instr(instr64),
    .wb_valid(1'b0), .wb_rd(4'd0), .wb_data(64'd0),
    .flush(1'b0),
    .out_valid(ov64), .out_ready(1'b1),
    .out_pc(opc64), .out_instr(oinstr64),
    .out_rs1_val(ors1_64), .out_rs2_val(ors2_64),
    .out_imm(oimm64), .out_rd(ord64), .out_rd_we(orwe64)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic [31:0] imm, input logic [4:0] rd,
                      input logic we);
    exp_t e;
    e.pc = pc; e.instr = ins; e.rs1 = r1; e.rs2 = r2;
    e.imm = imm; e.rd = rd; e.we = we;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: compare every accepted output against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual_pc=%h required=none",
                   out_pc);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_instr", out_instr, e.instr);
          chk("out_rs1_val", out_rs1_val, e.rs1);
          chk("out_rs2_val", out_rs2_val, e.rs2);
          chk("out_imm", out_imm, e.imm);
          chk("out_rd", out_rd, e.rd);
          chk("out_rd_we", out_rd_we, e.we);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    exp_t dummy;
    rst = 1; flush = 0; out_ready = 1;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    in_valid = 1; in_pc = 32'h100; in_instr = 32'h00500093;
    v64 = 0; pc64 = 0; instr64 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 32'h13);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_out_rd_we", out_rd_we, 0);

    // ADDI x1,x0,5 at 0x100
    rst = 0;
    #1 chk("addi_in_ready", in_ready, 1);
    push(32'h100, 32'h00500093, 0, 0, 5, 1, 1);
    cyc();
    chk("addi_out_valid", out_valid, 1);

    // ADD x3,x1,x2 stalls on x1
    in_pc = 32'h104; in_instr = 32'h002081B3;
    #1 chk("add_stall_outreg", in_ready, 0);
    cyc();
    #1 chk("add_stall_busy", in_ready, 0);
    cyc();
    wb_valid = 1; wb_rd = 1; wb_data = 5;
    #1 chk("add_wb_bypass_ready", in_ready, 1);
    push(32'h104, 32'h002081B3, 5, 0, 0, 3, 1);
    cyc();

    // writeback to x0 ignored; ADDI x5,x0,-1
    wb_rd = 0; wb_data = 32'hFFFF;
    in_pc = 32'h108; in_instr = 32'hFFF00293;
    #1 chk("addi_neg_ready", in_ready, 1);
    push(32'h108, 32'hFFF00293, 0, 0, 32'hFFFFFFFF, 5, 1);
    cyc();
    in_valid = 0; wb_rd = 3; wb_data = 32'h33;
    cyc();
    wb_rd = 5; wb_data = 32'h55;
    cyc();

    // BEQ x1,x3,8 held for 3 cycles
    wb_valid = 0; out_ready = 0;
    in_valid = 1; in_pc = 32'h10C; in_instr = 32'h00308463;
    #1 chk("beq_ready", in_ready, 1);
    push(32'h10C, 32'h00308463, 5, 32'h33, 8, 8, 0);
    cyc();
    in_pc = 32'h110; in_instr = 32'h00700313;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_pc", out_pc, 32'h10C);
      chk("hold_instr", out_instr, 32'h00308463);
      chk("hold_imm", out_imm, 8);
      chk("hold_in_ready", in_ready, 0);
      cyc();
    end
    out_ready = 1;
    #1 chk("release_ready", in_ready, 1);
    push(32'h110, 32'h00700313, 0, 0, 7, 6, 1);
    cyc();

    // ADDI x4,x0,9 then flush it
    in_pc = 32'h114; in_instr = 32'h00900213;
    push(32'h114, 32'h00900213, 0, 0, 9, 4, 1);
    cyc();
    flush = 1;
    in_pc = 32'h118; in_instr = 32'h000203B3;
    #1 chk("flush_in_ready", in_ready, 0);
    dummy = exp_q.pop_back();
    cyc();
    flush = 0;
    #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_instr", out_instr, 32'h13);
    chk("flush_dep_x4_ready", in_ready, 1);
    push(32'h118, 32'h000203B3, 0, 0, 0, 7, 1);
    cyc();

    // LUI, SW, JAL back to back
    in_pc = 32'h11C; in_instr = 32'h12345437;
    push(32'h11C, 32'h12345437, 0, 32'h33, 32'h12345000, 8, 1);
    cyc();
    in_pc = 32'h120; in_instr = 32'hFE21AE23;
    push(32'h120, 32'hFE21AE23, 32'h33, 0, 32'hFFFFFFFC, 28, 0);
    cyc();
    in_pc = 32'h124; in_instr = 32'hFFDFF0EF;
    push(32'h124, 32'hFFDFF0EF, 0, 0, 32'hFFFFFFFC, 1, 1);
    cyc();
    in_valid = 0;
    drain();

    // 64-bit, 16-register instance: SW x2,-4(x3)
    v64 = 1; pc64 = 64'h1000; instr64 = 32'hFE21AE23;
    cyc();
    v64 = 0;
    #1;
    chk("w64_out_valid", ov64, 1);
    chk("w64_out_imm", oimm64, 64'hFFFFFFFFFFFFFFFC);
    chk("w64_out_pc", opc64, 64'h1000);

    // reset mid-operation
    out_ready = 0;
    in_valid = 1; in_pc = 32'h200; in_instr = 32'h00900213;
    cyc();
    in_valid = 0; out_ready = 1; rst = 1;
    #1 chk("midrst_in_ready", in_ready, 0);
    cyc();
    rst = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_instr", out_instr, 32'h13);
    in_valid = 1; in_pc = 32'h204; in_instr = 32'h00308463;
    #1 chk("midrst_ready", in_ready, 1);
    push(32'h204, 32'h00308463, 0, 0, 8, 8, 0);
    cyc();
    in_valid = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
